// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: step sequencer for the 3x3 systolic-array datapath.
// Walks IDLE -> LOAD -> RUN -> DRAIN -> DONE. It steps cnt through 0..STEPS-1
// on valid operand cycles, waits DRAIN_CYC cycles for the array pipeline to
// empty, then pulses done.
// Optional feature: define SA_SEQ_CTRL_STALL_CNT_EN to build the stall counter;
// without it, stall_cnt is tied to zero.
module sa_seq_ctrl #(
  parameter int unsigned STEPS     = 9,
  parameter int unsigned CNT_W     = 4,
  parameter int unsigned DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic [CNT_W-1:0] cnt,
  output logic             step_en,
  output logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StDone} state_e;

  localparam logic [CNT_W-1:0] LastStep  = CNT_W'(STEPS - 1);
  localparam logic [3:0]       DrainInit = 4'(DRAIN_CYC - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       drain_q;

  // Sequencer state, step index and drain countdown; clear wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
    end else if (clear) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoad;
            cnt_q   <= '0;
          end
        end
        StLoad: state_q <= StRun;
        StRun: begin
          // Without operand data the array stalls; index and state hold.
          if (in_valid) begin
            if (cnt_q == LastStep) begin
              state_q <= StDrain;
              cnt_q   <= '0;
              drain_q <= DrainInit;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StDrain: begin
          if (drain_q == '0) begin
            state_q <= StDone;
          end else begin
            drain_q <= drain_q - 4'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode; step_en is the only output that looks at a live input.
  always_comb begin
    cnt     = cnt_q;
    step_en = (state_q == StRun) && in_valid;
    acc_clr = (state_q == StLoad);
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
  end

`ifdef SA_SEQ_CTRL_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count RUN cycles lost to missing data; zeroed on entry to LOAD, kept across clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!clear) begin
      if (state_q == StIdle && start) begin
        stall_q <= '0;
      end else if (state_q == StRun && !in_valid && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb_sa_seq_ctrl: directed scenarios plus random traffic for sa_seq_ctrl,
// checked every cycle against an operation-relative timeline model.
module tb_sa_seq_ctrl;

  localparam int unsigned STEPS     = 9;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DRAIN_CYC = 4;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             start    = 1'b0;
  logic             clear    = 1'b0;
  logic             in_valid = 1'b0;
  logic [CNT_W-1:0] cnt;
  logic             step_en;
  logic             acc_clr;
  logic             busy;
  logic             done;
  logic [15:0]      stall_cnt;

  sa_seq_ctrl #(
    .STEPS     (STEPS),
    .CNT_W     (CNT_W),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .in_valid  (in_valid),
    .cnt       (cnt),
    .step_en   (step_en),
    .acc_clr   (acc_clr),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: an operation is a timeline indexed by k, the cycles since LOAD.
  // k==0 is LOAD; RUN lasts until STEPS valid cycles have been seen (the
  // last one at k==m_end); then DRAIN_CYC drain cycles; then the done cycle.
  bit          m_active = 1'b0;
  int          m_k      = 0;
  int          m_steps  = 0;
  int          m_end    = -1;
  int unsigned m_stalls = 0;

  int cyc        = 0;
  int done_cyc   = -1;
  int done_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unsigned exp_stall();
`ifdef SA_SEQ_CTRL_STALL_CNT_EN
    return m_stalls;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_stalls = 0;
  endtask

  // One clock cycle: drive inputs, check all outputs against the model, then
  // advance the model with the inputs the DUT sampled at the edge.
  task automatic drive_cycle(input bit s, input bit c, input bit v);
    bit is_load, in_run, is_done;
    @(negedge clk);
    start    = s;
    clear    = c;
    in_valid = v;
    #1;
    is_load = m_active && (m_k == 0);
    in_run  = m_active && (m_k >= 1) && (m_steps < int'(STEPS));
    is_done = m_active && (m_end >= 0) && (m_k == m_end + int'(DRAIN_CYC) + 1);
    check_eq("cnt",       32'(cnt),       in_run ? m_steps : 0);
    check_eq("step_en",   32'(step_en),   32'(in_run && v));
    check_eq("acc_clr",   32'(acc_clr),   32'(is_load));
    check_eq("busy",      32'(busy),      32'(m_active));
    check_eq("done",      32'(done),      32'(is_done));
    check_eq("stall_cnt", 32'(stall_cnt), exp_stall());
    if (done === 1'b1) begin
      done_cyc = cyc;
      done_count++;
    end
    @(posedge clk);
    if (c) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_k      = 0;
        m_steps  = 0;
        m_end    = -1;
        m_stalls = 0;
      end
    end else begin
      if (in_run) begin
        if (v) begin
          m_steps++;
          if (m_steps == int'(STEPS)) m_end = m_k;
        end else if (m_stalls < 32'hFFFF) begin
          m_stalls++;
        end
      end
      if (is_done) m_active = 1'b0;
      m_k++;
    end
    cyc++;
  endtask

  initial begin
    int c0, d1, dc;

    // Reset values while rst_n is held low.
    #3;
    check_eq("rst_cnt",     32'(cnt),       0);
    check_eq("rst_step_en", 32'(step_en),   0);
    check_eq("rst_acc_clr", 32'(acc_clr),   0);
    check_eq("rst_busy",    32'(busy),      0);
    check_eq("rst_done",    32'(done),      0);
    check_eq("rst_stall",   32'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive_cycle(1'b0, 1'b0, 1'b1);

    // Single run with data always present: done 15 cycles after start.
    c0 = cyc;
    done_cyc = -1;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (17) drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("single_latency", 32'(done_cyc - c0), 15);

    // Three stall cycles at cnt==4 push done out to cycle 18.
    c0 = cyc;
    done_cyc = -1;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (5) drive_cycle(1'b0, 1'b0, 1'b1);
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);
    repeat (12) drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("stall_latency", 32'(done_cyc - c0), 18);
`ifdef SA_SEQ_CTRL_STALL_CNT_EN
    check_eq("stall_total", 32'(stall_cnt), 3);
`else
    check_eq("stall_total", 32'(stall_cnt), 0);
`endif

    // Abort at cnt==5: no done, then a fresh run completes normally.
    dc = done_count;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (6) drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    repeat (12) drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("abort_no_done", 32'(done_count - dc), 0);
    c0 = cyc;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (16) drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("after_abort_latency", 32'(done_cyc - c0), 15);

    // start held through the whole operation yields exactly one done.
    dc = done_count;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (15) drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (6) drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("ignored_start_dones", 32'(done_count - dc), 1);

    // start together with clear in IDLE stays idle.
    drive_cycle(1'b1, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("start_clear_idle", 32'(busy), 0);

    // Back-to-back: start in the cycle after done, dones 16 apart.
    c0 = cyc;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (15) drive_cycle(1'b0, 1'b0, 1'b1);
    d1 = done_cyc;
    check_eq("b2b_first", 32'(d1 - c0), 15);
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (17) drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("b2b_spacing", 32'(done_cyc - d1), 16);

    // Async reset in the middle of DRAIN, pulsed between clock edges.
    dc = done_count;
    drive_cycle(1'b1, 1'b0, 1'b1);
    repeat (11) drive_cycle(1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy",    32'(busy),      0);
    check_eq("arst_cnt",     32'(cnt),       0);
    check_eq("arst_step_en", 32'(step_en),   0);
    check_eq("arst_acc_clr", 32'(acc_clr),   0);
    check_eq("arst_done",    32'(done),      0);
    check_eq("arst_stall",   32'(stall_cnt), 0);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (20) drive_cycle(1'b0, 1'b0, 1'b1);
    check_eq("arst_no_done", 32'(done_count - dc), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 4) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
